// File: rtl/param_sp_ram.sv
// param_sp_ram: single-port RAM with byte enables, 1-cycle registered reads and a sequential clear engine.
// Optional per-byte even parity with a parity_err output when PARAM_SP_RAM_PARITY_EN is defined.
module param_sp_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int READ_MODE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic              we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
`ifdef PARAM_SP_RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   old_w, merged;
  logic                acc, wr;
  assign acc    = state_q == READY && en && !clr;
  assign wr     = acc && we;
  assign busy   = state_q == CLEAR;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  always_comb begin
    old_w  = mem_q[addr];
    merged = old_w;
    for (int i = 0; i < NB; i++) merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_w[8*i +: 8];
    rdata_d = (we && READ_MODE != 0) ? merged : old_w;
  end
  // Array has no reset; the clear engine owns initialisation.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem_q[cnt_q] <= '0;
    else if (wr) mem_q[addr] <= merged;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= acc;
      if (acc) rdata_q <= rdata_d;
      if (state_q == CLEAR) begin
        cnt_q   <= clr ? '0 : cnt_q + ADDR_W'(1);
        state_q <= (!clr && &cnt_q) ? READY : CLEAR;
      end else if (clr) begin
        state_q <= CLEAR;
        cnt_q   <= '0;
      end
    end
  end
`ifdef PARAM_SP_RAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] par_new, rd_p;
  logic          err, perr_q;
  always_comb begin
    par_new = par_q[addr];
    for (int i = 0; i < NB; i++) if (be[i]) par_new[i] = ^wdata[8*i +: 8];
    rd_p = (we && READ_MODE != 0) ? par_new : par_q[addr];
    err  = 1'b0;
    for (int i = 0; i < NB; i++) err = err | ((^rdata_d[8*i +: 8]) ^ rd_p[i]);
  end
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) par_q[cnt_q] <= '0;
    else if (wr) par_q[addr] <= par_new;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perr_q <= 1'b0;
    else perr_q <= acc && err;
  end
  assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_param_sp_ram.sv
// tb_param_sp_ram: directed checks of a 32-bit read-first and an 8-bit write-first param_sp_ram.
module tb_param_sp_ram;
  logic        clk = 1'b0;
  logic        reset_n, clr, en, we;
  logic [3:0]  be, addr;
  logic [31:0] wdata, rd0;
  logic [7:0]  rd1;
  logic        rv0, rv1, busy0, busy1;
  int          checks = 0, failures = 0, n;
`ifdef PARAM_SP_RAM_PARITY_EN
  logic        perr0, perr1;
`endif
  always #5 clk = ~clk;
  param_sp_ram #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .rdata(rd0), .rvalid(rv0), .busy(busy0)
`ifdef PARAM_SP_RAM_PARITY_EN
    , .parity_err(perr0)
`endif
  );
  param_sp_ram #(.DATA_W(8), .ADDR_W(4), .READ_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .we(we), .be(be[0]), .addr(addr),
    .wdata(wdata[7:0]), .rdata(rd1), .rvalid(rv1), .busy(busy1)
`ifdef PARAM_SP_RAM_PARITY_EN
    , .parity_err(perr1)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic e, input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    en = e; we = w; addr = a; wdata = d; be = b;
    tick();
  endtask
  task automatic test_reset();
    reset_n = 1'b0; clr = 1'b0; en = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    #12;
    checks++;
    if (busy0 !== 1'b1 || rv0 !== 1'b0 || rd0 !== 32'h0 || busy1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== 8'h0) begin
      failures++;
      $display("FAIL reset_state busy=%b rv=%b rd=%h busy1=%b rv1=%b rd1=%h want busy=1 rv=0 rd=0", busy0, rv0, rd0, busy1, rv1, rd1);
    end
  endtask
  task automatic test_clear_ignore();
    int rv_seen = 0;
    en = 1'b1; we = 1'b1; addr = 4'd3; wdata = 32'hAAAAAAAA; be = 4'hF;
    #2 reset_n = 1'b1;
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
      if (rv0 || rv1) rv_seen++;
    end
    en = 1'b0;
    checks++;
    if (n !== 16) begin failures++; $display("FAIL clear_len got=%0d want=16", n); end
    checks++;
    if (rv_seen !== 0) begin failures++; $display("FAIL rvalid_in_clear got=%0d want=0", rv_seen); end
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL busy1_after_clear got=%b want=0", busy1); end
  endtask
  task automatic test_read_all();
    for (int a = 0; a < 16; a++) begin
      op(1'b1, 1'b0, 4'(a), 32'h0, 4'h0);
      checks++;
      if (rv0 !== 1'b1 || rd0 !== 32'h0 || rv1 !== 1'b1 || rd1 !== 8'h0) begin
        failures++;
        $display("FAIL read_zero a=%0d rv=%b rd=%h rv1=%b rd1=%h want rv=1 rd=0", a, rv0, rd0, rv1, rd1);
      end
    end
    op(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    checks++;
    if (rv0 !== 1'b0 || rv1 !== 1'b0) begin failures++; $display("FAIL idle_rvalid got=%b/%b want=0", rv0, rv1); end
  endtask
  task automatic test_byte_enable();
    op(1'b1, 1'b1, 4'd5, 32'h11223344, 4'b1111);
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 32'h0 || rd1 !== 8'h44) begin
      failures++; $display("FAIL be_wr1 rv=%b rd=%h rd1=%h want 1/00000000/44", rv0, rd0, rd1);
    end
    op(1'b1, 1'b1, 4'd5, 32'hAABBCCDD, 4'b0101);
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 32'h11223344 || rd1 !== 8'hDD) begin
      failures++; $display("FAIL be_wr2 rv=%b rd=%h rd1=%h want 1/11223344/dd", rv0, rd0, rd1);
    end
    op(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 32'h11BB33DD || rd1 !== 8'hDD) begin
      failures++; $display("FAIL be_rd rv=%b rd=%h rd1=%h want 1/11bb33dd/dd", rv0, rd0, rd1);
    end
    op(1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'b0000);
    checks++;
    if (rv0 !== 1'b1 || rv1 !== 1'b1 || rd0 !== 32'h11BB33DD || rd1 !== 8'hDD) begin
      failures++; $display("FAIL be_zero_wr rv=%b/%b rd=%h rd1=%h want 1/1/11bb33dd/dd", rv0, rv1, rd0, rd1);
    end
    op(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    checks++;
    if (rd0 !== 32'h11BB33DD || rd1 !== 8'hDD) begin
      failures++; $display("FAIL be_zero_rd rd=%h rd1=%h want 11bb33dd/dd", rd0, rd1);
    end
  endtask
  task automatic test_read_mode();
    op(1'b1, 1'b1, 4'd2, 32'h0000005A, 4'hF);
    op(1'b1, 1'b1, 4'd2, 32'h000000C3, 4'hF);
    checks++;
    if (rv0 !== 1'b1 || rv1 !== 1'b1 || rd0 !== 32'h5A || rd1 !== 8'hC3) begin
      failures++; $display("FAIL rdw_mode rv=%b/%b rd0=%h rd1=%h want 1/1/0000005a/c3", rv0, rv1, rd0, rd1);
    end
    op(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    checks++;
    if (rd0 !== 32'hC3 || rd1 !== 8'hC3) begin failures++; $display("FAIL rd_after_wr rd0=%h rd1=%h want c3", rd0, rd1); end
    op(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    checks++;
    if (rv0 !== 1'b0 || rd0 !== 32'hC3 || rd1 !== 8'hC3) begin
      failures++; $display("FAIL rdata_hold rv=%b rd0=%h rd1=%h want 0/c3/c3", rv0, rd0, rd1);
    end
  endtask
  task automatic test_clr();
    clr = 1'b1;
    op(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    clr = 1'b0; en = 1'b0;
    checks++;
    if (rv0 !== 1'b0 || busy0 !== 1'b1 || rd0 !== 32'hC3) begin
      failures++; $display("FAIL clr_wins rv=%b busy=%b rd=%h want 0/1/000000c3", rv0, busy0, rd0);
    end
    n = 1;
    while (busy0 && n < 40) begin tick(); if (busy0) n++; end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL clr_len got=%0d want=16", n); end
    op(1'b1, 1'b0, 4'd5, 32'h0, 4'h0);
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 32'h0 || rd1 !== 8'h0) begin
      failures++; $display("FAIL clr_data5 rv=%b rd=%h rd1=%h want 1/0/0", rv0, rd0, rd1);
    end
    op(1'b1, 1'b0, 4'd2, 32'h0, 4'h0);
    checks++;
    if (rd0 !== 32'h0 || rd1 !== 8'h0) begin failures++; $display("FAIL clr_data2 rd=%h rd1=%h want 0", rd0, rd1); end
  endtask
  task automatic test_reset_mid_clear();
    op(1'b1, 1'b1, 4'd9, 32'h12345678, 4'hF);
    op(1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    checks++;
    if (rd0 !== 32'h12345678 || rd1 !== 8'h78) begin failures++; $display("FAIL pre_rst_rd rd=%h rd1=%h want 12345678/78", rd0, rd1); end
    clr = 1'b1;
    op(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    clr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (busy0 !== 1'b1 || rd0 !== 32'h12345678) begin
      failures++; $display("FAIL mid_clear busy=%b rd=%h want 1/12345678", busy0, rd0);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b1 || rv0 !== 1'b0 || rd0 !== 32'h0 || rd1 !== 8'h0) begin
      failures++; $display("FAIL async_rst busy=%b rv=%b rd=%h rd1=%h want 1/0/0/0", busy0, rv0, rd0, rd1);
    end
    tick();
    #2 reset_n = 1'b1;
    n = 0;
    while (busy0 && n < 40) begin tick(); n++; end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL rst_clear_len got=%0d want=16", n); end
    op(1'b1, 1'b0, 4'd9, 32'h0, 4'h0);
    checks++;
    if (rv0 !== 1'b1 || rd0 !== 32'h0 || rd1 !== 8'h0) begin
      failures++; $display("FAIL rst_data9 rv=%b rd=%h rd1=%h want 1/0/0", rv0, rd0, rd1);
    end
  endtask
`ifdef PARAM_SP_RAM_PARITY_EN
  task automatic test_parity();
    op(1'b1, 1'b1, 4'd1, 32'hA5A5A5A5, 4'hF);
    op(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    checks++;
    if (rv0 !== 1'b1 || perr0 !== 1'b0) begin failures++; $display("FAIL par_clean rv=%b perr=%b want 1/0", rv0, perr0); end
    u0.mem_q[1] = u0.mem_q[1] ^ 32'h00000800;
    op(1'b1, 1'b0, 4'd1, 32'h0, 4'h0);
    checks++;
    if (rv0 !== 1'b1 || perr0 !== 1'b1) begin failures++; $display("FAIL par_flip rv=%b perr=%b want 1/1", rv0, perr0); end
    op(1'b0, 1'b0, 4'd0, 32'h0, 4'h0);
    checks++;
    if (perr0 !== 1'b0 || perr1 !== 1'b0) begin failures++; $display("FAIL par_idle perr=%b/%b want 0", perr0, perr1); end
  endtask
`endif
  initial begin
    test_reset();
    test_clear_ignore();
    test_read_all();
    test_byte_enable();
    test_read_mode();
    test_clr();
    test_reset_mid_clear();
`ifdef PARAM_SP_RAM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
